// File: rtl/mig_ui_adapter.sv
// mig_ui_adapter: bridges a single-beat valid/ready request port onto the MIG
// DDR3 user interface. Holds each command and write beat until the MIG takes
// it, registers read returns, limits outstanding reads with a credit counter,
// and raises a sticky error on orphan read data or a stalled UI handshake.
module mig_ui_adapter #(
    parameter int ADDR_WIDTH     = 27,
    parameter int APP_DATA_WIDTH = 256,
    parameter int MAX_READS      = 16,
    parameter int TIMEOUT        = 1023
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_read,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [APP_DATA_WIDTH-1:0] req_data,
    input  logic                      app_rdy,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    input  logic                      app_wdf_rdy,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    input  logic                      app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      rd_valid,
    output logic [APP_DATA_WIDTH-1:0] rd_data,
    output logic                      error
);

    localparam int CW = $clog2(MAX_READS) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] MaxReadsC = CW'(MAX_READS);
    localparam logic [TW-1:0] TimeoutC  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TimeoutM1 = TW'(TIMEOUT - 1);

    logic                      cmdFull_q, cmdFull_d;
    logic                      cmdRead_q, cmdRead_d;
    logic [ADDR_WIDTH-1:0]     cmdAddr_q, cmdAddr_d;
    logic                      wdfFull_q, wdfFull_d;
    logic [APP_DATA_WIDTH-1:0] wdfData_q, wdfData_d;
    logic                      rdValid_q, rdValid_d;
    logic [APP_DATA_WIDTH-1:0] rdData_q, rdData_d;
    logic                      error_q, error_d;
    logic [CW-1:0]             readsInFlight_q, readsInFlight_d;
    logic [TW-1:0]             cmdStallCnt_q, cmdStallCnt_d;
    logic [TW-1:0]             wdfStallCnt_q, wdfStallCnt_d;

    logic cmdFree, wdfFree, credit, accept;
    logic incRead, decRead, orphan;
    logic cmdStall, wdfStall, cmdTimeout, wdfTimeout;

    // Handshake decode: a slot is free if empty or draining this cycle; the
    // credit check uses only registered state so a return frees credit next cycle.
    always_comb begin
        cmdFree    = !cmdFull_q || app_rdy;
        wdfFree    = !wdfFull_q || app_wdf_rdy;
        credit     = readsInFlight_q < MaxReadsC;
        req_ready  = cmdFree && wdfFree && credit;
        accept     = req_valid && req_ready;
        incRead    = accept && req_read;
        orphan     = app_rd_data_valid && (readsInFlight_q == '0);
        decRead    = app_rd_data_valid && !orphan;
        cmdStall   = cmdFull_q && !app_rdy;
        wdfStall   = wdfFull_q && !app_wdf_rdy;
        cmdTimeout = cmdStall && (cmdStallCnt_q >= TimeoutM1);
        wdfTimeout = wdfStall && (wdfStallCnt_q >= TimeoutM1);
    end

    // Next-state: drain slots, then let an accepted request reload them.
    always_comb begin
        cmdFull_d = cmdFull_q && !app_rdy;
        cmdRead_d = cmdRead_q;
        cmdAddr_d = cmdAddr_q;
        wdfFull_d = wdfFull_q && !app_wdf_rdy;
        wdfData_d = wdfData_q;
        if (accept) begin
            cmdFull_d = 1'b1;
            cmdRead_d = req_read;
            cmdAddr_d = req_addr;
            if (!req_read) begin
                wdfFull_d = 1'b1;
                wdfData_d = req_data;
            end
        end

        readsInFlight_d = readsInFlight_q;
        if (incRead && !decRead) begin
            readsInFlight_d = readsInFlight_q + 1'b1;
        end else if (!incRead && decRead) begin
            readsInFlight_d = readsInFlight_q - 1'b1;
        end

        rdValid_d = app_rd_data_valid;
        rdData_d  = app_rd_data_valid ? app_rd_data : rdData_q;

        cmdStallCnt_d = '0;
        if (cmdStall) begin
            cmdStallCnt_d = (cmdStallCnt_q == TimeoutC) ? cmdStallCnt_q : cmdStallCnt_q + 1'b1;
        end
        wdfStallCnt_d = '0;
        if (wdfStall) begin
            wdfStallCnt_d = (wdfStallCnt_q == TimeoutC) ? wdfStallCnt_q : wdfStallCnt_q + 1'b1;
        end

        error_d = error_q || orphan || cmdTimeout || wdfTimeout;
    end

    // State registers; reset discards pending slots and all credits at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmdFull_q       <= 1'b0;
            cmdRead_q       <= 1'b0;
            cmdAddr_q       <= '0;
            wdfFull_q       <= 1'b0;
            wdfData_q       <= '0;
            rdValid_q       <= 1'b0;
            rdData_q        <= '0;
            error_q         <= 1'b0;
            readsInFlight_q <= '0;
            cmdStallCnt_q   <= '0;
            wdfStallCnt_q   <= '0;
        end else begin
            cmdFull_q       <= cmdFull_d;
            cmdRead_q       <= cmdRead_d;
            cmdAddr_q       <= cmdAddr_d;
            wdfFull_q       <= wdfFull_d;
            wdfData_q       <= wdfData_d;
            rdValid_q       <= rdValid_d;
            rdData_q        <= rdData_d;
            error_q         <= error_d;
            readsInFlight_q <= readsInFlight_d;
            cmdStallCnt_q   <= cmdStallCnt_d;
            wdfStallCnt_q   <= wdfStallCnt_d;
        end
    end

    assign app_en       = cmdFull_q;
    assign app_cmd      = {2'b00, cmdRead_q};
    assign app_addr     = cmdAddr_q;
    assign app_wdf_wren = wdfFull_q;
    assign app_wdf_end  = 1'b1;
    assign app_wdf_data = wdfData_q;
    assign rd_valid     = rdValid_q;
    assign rd_data      = rdData_q;
    assign error        = error_q;

endmodule

// File: doc/mig_ui_adapter.md
Name: mig_ui_adapter

Overview:
- Sits between a traffic-generating/application block and the MIG DDR3 user interface (UI).
- Accepts single-beat write/read requests on a valid/ready port and drives app_en/app_cmd/app_addr and app_wdf_* with correct hold-until-ready semantics.
- Registers returning read data and limits outstanding reads with a credit counter.
- Flags protocol faults (orphan read data, UI stall timeout) on a sticky error output.

Parameters:
- ADDR_WIDTH, 27, width of req_addr/app_addr.
- APP_DATA_WIDTH, 256, width of write/read data (one BL8 burst, 4:1 UI, single beat).
- MAX_READS, 16, maximum reads accepted but not yet returned; power of 2, at least 2.
- TIMEOUT, 1023, cycles app_en or app_wdf_wren may be held without acceptance before error.

Ports:
- clk  in  1  UI clock.
- reset  in  1  Asynchronous, active-high; all registers clear immediately.
- req_valid  in  1  Upstream request present.
- req_ready  out  1  Adapter accepts the request this cycle.
- req_read  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_WIDTH  Burst address.
- req_data  in  APP_DATA_WIDTH  Write data; ignored for reads.
- app_rdy  in  1  MIG command accept.
- app_en  out  1  Command valid.
- app_cmd  out  3  3'b001 read, 3'b000 write.
- app_addr  out  ADDR_WIDTH  Command address.
- app_wdf_rdy  in  1  MIG write-data accept.
- app_wdf_wren  out  1  Write data valid.
- app_wdf_end  out  1  Constant 1 (single-beat burst).
- app_wdf_data  out  APP_DATA_WIDTH  Write data.
- app_rd_data_valid  in  1  MIG read return.
- app_rd_data  in  APP_DATA_WIDTH  MIG read data.
- rd_valid  out  1  Registered read return; no backpressure.
- rd_data  out  APP_DATA_WIDTH  Registered read data.
- error  out  1  Sticky fault flag.

Behaviour:
- Reset values: app_en=0, app_cmd=0, app_addr=0, app_wdf_wren=0, app_wdf_data=0, rd_valid=0, rd_data=0, error=0, reads_in_flight=0, both stall counters=0.
- Command slot: app_en is the slot-full flag. The slot drains on app_en && app_rdy. app_cmd and app_addr hold stable while app_en=1 && !app_rdy.
- Write-data slot: app_wdf_wren is the slot-full flag. The slot drains on app_wdf_wren && app_wdf_rdy. app_wdf_data holds stable while waiting.
- cmd_free = !app_en || app_rdy.
- wdf_free = !app_wdf_wren || app_wdf_rdy.
- credit = reads_in_flight < MAX_READS.
- req_ready = cmd_free && wdf_free && credit. This is combinational from registered state and the two rdy inputs; it is independent of req_valid and req_read.
- Accept = req_valid && req_ready. On accept:
  - The command slot loads next cycle: app_en=1, app_cmd={2'b00,req_read}, app_addr=req_addr.
  - For a write, the data slot loads simultaneously: app_wdf_wren=1, app_wdf_data=req_data. Data is never presented later than its command.
  - For a read, the data slot is untouched.
- Back-to-back: with app_rdy=app_wdf_rdy=1 continuously, one request is accepted per cycle, and app_en stays high across consecutive requests.
- A slot that drains with no new accept clears its flag next cycle.
- reads_in_flight (log2(MAX_READS)+1 bits):
  - +1 on accept of a read.
  - -1 on app_rd_data_valid.
  - Both in the same cycle: unchanged.
  - No same-cycle credit bypass: at MAX_READS, req_ready stays 0 until the cycle after a return.
- Read return: rd_valid/rd_data are app_rd_data_valid/app_rd_data delayed by exactly 1 clk. rd_data updates only when app_rd_data_valid=1.
- Error sources (error is sticky until reset; normal operation continues after it is set):
  - app_rd_data_valid=1 while reads_in_flight=0. The counter does not decrement (saturates at 0); the data is still forwarded.
  - app_en=1 && !app_rdy for TIMEOUT consecutive cycles. A separate counter tracks this and resets on app_rdy or !app_en.
  - app_wdf_wren=1 && !app_wdf_rdy for TIMEOUT consecutive cycles, via its own counter.
- Reset mid-operation: pending command, write data and credits are discarded. Issued-but-unreturned reads arriving after reset trip the orphan error; this is intended.

Test Plan:
- Write streaming: 8 writes, addr 0x1ff0 step 8, data 1..8, rdy inputs held 1 -> app_en and app_wdf_wren high 8 consecutive cycles, app_cmd=0, addresses/data in order, error=0.
- Command stall: app_rdy=0 for 5 cycles while a read at addr 0x2000 is pending -> app_en, app_cmd=1, app_addr=0x2000 stable; req_ready=0; one command issued when app_rdy returns.
- Split ready: app_rdy=1, app_wdf_rdy=0 for 3 cycles on a write -> command drains, data held; req_ready=0 until app_wdf_rdy=1.
- Credit limit: 16 reads issued with no returns -> req_ready=0 after the 16th; one app_rd_data_valid -> req_ready=1 the following cycle; rd_valid appears 1 cycle after each return.
- Orphan/timeout: app_rd_data_valid with no reads pending -> error=1 next cycle, rd_valid still pulses. Separately, app_rdy=0 for 1023 cycles with app_en=1 -> error=1.
- Async reset mid-burst: reset asserted while 3 reads are in flight and a write is pending -> app_en, app_wdf_wren, rd_valid, error=0 immediately, without waiting for a clk edge.
